// File: rtl/fechadura_pkg.sv
// Shared types and display constants for the parametrised combination lock.
// Segment patterns are ordered {A,B,C,D,E,F,G}, active-high.
package fechadura_pkg;

  typedef enum logic [1:0] {
    ENTRADA   = 2'd0,
    ABERTO    = 2'd1,
    ERRO      = 2'd2,
    BLOQUEADO = 2'd3
  } estado_t;

  localparam logic [4:0] COD_A       = 5'h0A;
  localparam logic [4:0] COD_B       = 5'h0B;
  localparam logic [4:0] COD_E       = 5'h0E;
  localparam logic [4:0] COD_TRACO   = 5'd16;
  localparam logic [4:0] COD_APAGADO = 5'd17;

  localparam logic [6:0] SEG_PADRAO [18] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
    7'b0000001, 7'b0000000
  };

  localparam logic [6:0] SEG_TRACO = 7'b0000001;

endpackage

// File: rtl/fechadura_param_decod_7seg.sv
// Combinational 5-bit display code to 7-segment decoder.
// Codes above COD_APAGADO render blank.
module decod_7seg
  import fechadura_pkg::*;
(
  input  logic [4:0] cod,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_PADRAO[COD_APAGADO];
    if (cod <= COD_APAGADO) seg = SEG_PADRAO[cod];
  end

endmodule

// File: rtl/fechadura_param.sv
// Parametrised sequential combination lock with full-sequence evaluation,
// timed open/error/lockout windows and a consecutive-failure counter.
module fechadura_param
  import fechadura_pkg::*;
#(
  parameter int                      NUM_DIGITS = 6,
  parameter logic [NUM_DIGITS*4-1:0] SENHA      = 24'h590981,
  parameter int                      MAX_FALHAS = 3,
  parameter int                      T_ABERTO   = 8,
  parameter int                      T_ERRO     = 4,
  parameter int                      T_BLOQUEIO = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            insere,
  input  logic [3:0]                      numero,
  output logic                            LED,
  output logic                            erro,
  output logic                            bloqueado,
  output logic [$clog2(NUM_DIGITS+1)-1:0] contagem,
  output logic                            A,
  output logic                            B,
  output logic                            C,
  output logic                            D,
  output logic                            E,
  output logic                            F,
  output logic                            G
);

  localparam int CW    = $clog2(NUM_DIGITS + 1);
  localparam int T_MAX = (T_ABERTO > T_ERRO) ?
                         ((T_ABERTO > T_BLOQUEIO) ? T_ABERTO : T_BLOQUEIO) :
                         ((T_ERRO > T_BLOQUEIO) ? T_ERRO : T_BLOQUEIO);
  localparam int TW    = ($clog2(T_MAX) < 1) ? 1 : $clog2(T_MAX);
  localparam int FW    = ($clog2(MAX_FALHAS + 1) < 1) ? 1 : $clog2(MAX_FALHAS + 1);

  localparam logic [TW-1:0] CARGA_ABERTO   = TW'(T_ABERTO - 1);
  localparam logic [TW-1:0] CARGA_ERRO     = TW'(T_ERRO - 1);
  localparam logic [TW-1:0] CARGA_BLOQUEIO = TW'(T_BLOQUEIO - 1);

  estado_t       estado, estado_n;
  logic          insere_q;
  logic          falhou, falhou_n, falhou_total;
  logic [3:0]    digito, digito_n, esperado;
  logic [CW-1:0] contagem_n;
  logic [TW-1:0] timer, timer_n;
  logic [FW-1:0] falhas, falhas_n, falhas_inc;
  logic [4:0]    cod_n;
  logic [6:0]    seg_q, seg_n;
  logic          evento;

  assign evento     = insere & ~insere_q;
  assign falhas_inc = falhas + FW'(1);

  // Nibble of the password selected by the number of digits already entered.
  always_comb begin
    esperado = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (contagem == CW'(i)) esperado = SENHA[(NUM_DIGITS-1-i)*4 +: 4];
  end

  always_comb begin
    estado_n     = estado;
    contagem_n   = contagem;
    falhou_n     = falhou;
    digito_n     = digito;
    timer_n      = timer;
    falhas_n     = falhas;
    falhou_total = falhou | (numero != esperado);
    case (estado)
      ENTRADA: begin
        if (evento) begin
          digito_n = numero;
          if (contagem == CW'(NUM_DIGITS - 1)) begin
            contagem_n = '0;
            falhou_n   = 1'b0;
            if (!falhou_total) begin
              estado_n = ABERTO;
              timer_n  = CARGA_ABERTO;
              falhas_n = '0;
            end else if (falhas_inc == FW'(MAX_FALHAS)) begin
              estado_n = BLOQUEADO;
              timer_n  = CARGA_BLOQUEIO;
              falhas_n = '0;
            end else begin
              estado_n = ERRO;
              timer_n  = CARGA_ERRO;
              falhas_n = falhas_inc;
            end
          end else begin
            contagem_n = contagem + CW'(1);
            falhou_n   = falhou_total;
          end
        end
      end
      default: begin
        if (timer == '0) estado_n = ENTRADA;
        else             timer_n  = timer - TW'(1);
      end
    endcase
  end

  // Display code follows the next state so it changes on the same edge.
  always_comb begin
    case (estado_n)
      ABERTO:    cod_n = COD_A;
      ERRO:      cod_n = COD_E;
      BLOQUEADO: cod_n = COD_B;
      default:   cod_n = (contagem_n == '0) ? COD_TRACO : {1'b0, digito_n};
    endcase
  end

  decod_7seg u_decod (
    .cod (cod_n),
    .seg (seg_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado    <= ENTRADA;
      insere_q  <= 1'b0;
      contagem  <= '0;
      falhou    <= 1'b0;
      digito    <= '0;
      timer     <= '0;
      falhas    <= '0;
      LED       <= 1'b0;
      erro      <= 1'b0;
      bloqueado <= 1'b0;
      seg_q     <= SEG_TRACO;
    end else begin
      estado    <= estado_n;
      insere_q  <= insere;
      contagem  <= contagem_n;
      falhou    <= falhou_n;
      digito    <= digito_n;
      timer     <= timer_n;
      falhas    <= falhas_n;
      LED       <= (estado_n == ABERTO);
      erro      <= (estado_n == ERRO);
      bloqueado <= (estado_n == BLOQUEADO);
      seg_q     <= seg_n;
    end
  end

  assign {A, B, C, D, E, F, G} = seg_q;

endmodule

// File: tb/tb_fechadura_param.sv
// Bench for fechadura_param: default instance plus a 4-digit, single-failure
// instance, both checked every cycle against a behavioural model.
module tb_fechadura_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       ins [2] = '{1'b0, 1'b0};
  logic [3:0] num [2] = '{4'd0, 4'd0};
  logic       led0, err0, blk0, led1, err1, blk1;
  logic [2:0] cnt0, cnt1;
  logic [6:0] s0, s1;

  fechadura_param dut0 (
    .clk(clk), .reset(rst_n), .insere(ins[0]), .numero(num[0]),
    .LED(led0), .erro(err0), .bloqueado(blk0), .contagem(cnt0),
    .A(s0[6]), .B(s0[5]), .C(s0[4]), .D(s0[3]), .E(s0[2]), .F(s0[1]), .G(s0[0])
  );

  fechadura_param #(
    .NUM_DIGITS(4), .SENHA(16'h1234), .MAX_FALHAS(1),
    .T_ABERTO(3), .T_ERRO(2), .T_BLOQUEIO(5)
  ) dut1 (
    .clk(clk), .reset(rst_n), .insere(ins[1]), .numero(num[1]),
    .LED(led1), .erro(err1), .bloqueado(blk1), .contagem(cnt1),
    .A(s1[6]), .B(s1[5]), .C(s1[4]), .D(s1[3]), .E(s1[2]), .F(s1[1]), .G(s1[0])
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 entry, 1 open, 2 error, 3 lockout. Entered digits accumulate
  // as a number and are compared with the password once all are in.
  int          p_n    [2] = '{6, 4};
  int unsigned p_pw   [2] = '{32'h590981, 32'h1234};
  int          p_maxf [2] = '{3, 1};
  int          p_ta   [2] = '{8, 3};
  int          p_te   [2] = '{4, 2};
  int          p_tb   [2] = '{16, 5};

  int          m_mode  [2] = '{0, 0};
  int          m_left  [2] = '{0, 0};
  int          m_fails [2] = '{0, 0};
  int          m_cnt   [2] = '{0, 0};
  int unsigned m_val   [2] = '{0, 0};
  logic        m_prev  [2] = '{1'b0, 1'b0};
  int          m_last  [2] = '{0, 0};

  task automatic model_reset(input int k);
    m_mode[k] = 0; m_left[k] = 0; m_fails[k] = 0; m_cnt[k] = 0;
    m_val[k] = 0; m_prev[k] = 1'b0; m_last[k] = 0;
  endtask

  task automatic model_step(input int k, input logic in, input logic [3:0] d);
    logic ev;
    ev = in && !m_prev[k];
    m_prev[k] = in;
    if (m_mode[k] == 0) begin
      if (ev) begin
        m_val[k] = m_val[k] * 16 + int'(d);
        m_cnt[k]++;
        m_last[k] = int'(d);
        if (m_cnt[k] == p_n[k]) begin
          if (m_val[k] == p_pw[k]) begin
            m_mode[k] = 1; m_left[k] = p_ta[k]; m_fails[k] = 0;
          end else begin
            m_fails[k]++;
            if (m_fails[k] == p_maxf[k]) begin
              m_mode[k] = 3; m_left[k] = p_tb[k]; m_fails[k] = 0;
            end else begin
              m_mode[k] = 2; m_left[k] = p_te[k];
            end
          end
          m_val[k] = 0;
          m_cnt[k] = 0;
        end
      end
    end else begin
      m_left[k]--;
      if (m_left[k] == 0) m_mode[k] = 0;
    end
  endtask

  function automatic logic [6:0] seg_of(input int h);
    case (h)
      0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
      3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
      6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
      9: return 7'b1111011; 10: return 7'b1110111; 11: return 7'b0011111;
     12: return 7'b1001110; 13: return 7'b0111101; 14: return 7'b1001111;
     15: return 7'b1000111;
      default: return 7'b0000001;
    endcase
  endfunction

  function automatic logic [12:0] exp_vec(input int k);
    logic [6:0] disp;
    case (m_mode[k])
      1: disp = seg_of(10);
      2: disp = seg_of(14);
      3: disp = seg_of(11);
      default: disp = (m_cnt[k] == 0) ? 7'b0000001 : seg_of(m_last[k]);
    endcase
    return {m_mode[k] == 1, m_mode[k] == 2, m_mode[k] == 3, 3'(m_cnt[k]), disp};
  endfunction

  function automatic logic [12:0] dut_vec(input int k);
    if (k == 0) return {led0, err0, blk0, cnt0, s0};
    return {led1, err1, blk1, cnt1, s1};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, ins[0], num[0]);
      model_step(1, ins[1], num[1]);
    end
  end

  always @(posedge clk) begin
    #2;
    chk("cycle_dut0", 32'(dut_vec(0)), 32'(exp_vec(0)));
    chk("cycle_dut1", 32'(dut_vec(1)), 32'(exp_vec(1)));
  end

  // ---------------- driver tasks ----------------
  task automatic digit(input int k, input logic [3:0] d);
    @(negedge clk); ins[k] = 1'b1; num[k] = d;
    @(negedge clk); ins[k] = 1'b0;
  endtask

  function automatic logic [2:0] flags(input int k);
    return (k == 0) ? {led0, err0, blk0} : {led1, err1, blk1};
  endfunction

  task automatic wait_idle(input int k, output int n);
    n = 0;
    while (flags(k) != 3'b000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 40), 32'd1);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  typedef struct {
    logic [23:0] seq;
    int          res;   // 0 open, 1 error, 2 lockout
  } vec_t;

  vec_t tbl [8];

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    int exp_len;
    logic [2:0] exp_flags;
    logic [3:0] d;

    tbl[0] = '{24'h590981, 0};
    tbl[1] = '{24'h590982, 1};
    tbl[2] = '{24'h590981, 0};
    tbl[3] = '{24'h123456, 1};
    tbl[4] = '{24'h000000, 1};
    tbl[5] = '{24'h590980, 2};
    tbl[6] = '{24'h999999, 1};
    tbl[7] = '{24'h590981, 0};

    // Reset held while insere toggles.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); ins[0] = ~ins[0]; num[0] = 4'(i);
    end
    chk("reset_hold", 32'(dut_vec(0)), 32'h001);
    @(negedge clk); ins[0] = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("after_release_cnt", 32'(cnt0), 32'd0);

    // Table of full sequences.
    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < 6; j++) begin
        d = 4'(tbl[t].seq >> (4 * (5 - j)));
        digit(0, d);
        if (j < 5) chk("table_cnt", 32'(cnt0), 32'(j + 1));
      end
      exp_flags = (tbl[t].res == 0) ? 3'b100 : (tbl[t].res == 1) ? 3'b010 : 3'b001;
      chk("table_flags", 32'(flags(0)), 32'(exp_flags));
      exp_len = (tbl[t].res == 0) ? 8 : (tbl[t].res == 1) ? 4 : 12;
      if (tbl[t].res == 2) begin
        digit(0, 4'd5);
        digit(0, 4'd9);
        chk("lockout_ignores", 32'(cnt0), 32'd0);
      end
      wait_idle(0, n);
      chk("window_len", 32'(n), 32'(exp_len));
      chk("idle_dash", 32'(s0), 32'h01);
    end

    // insere held high for 10 cycles accepts one digit.
    @(negedge clk); ins[0] = 1'b1; num[0] = 4'd7;
    repeat (10) @(negedge clk);
    chk("held_cnt", 32'(cnt0), 32'd1);
    chk("held_disp", 32'(s0), 32'(seg_of(7)));
    ins[0] = 1'b0;
    pulse_reset();

    // insere rising during the open window is not a digit afterwards.
    for (int j = 0; j < 6; j++) digit(0, 4'(24'h590981 >> (4 * (5 - j))));
    chk("open_led", 32'(led0), 32'd1);
    @(negedge clk); ins[0] = 1'b1; num[0] = 4'd5;
    repeat (12) @(negedge clk);
    chk("rise_in_open_led", 32'(led0), 32'd0);
    chk("rise_in_open_cnt", 32'(cnt0), 32'd0);
    ins[0] = 1'b0;
    digit(0, 4'd5);
    chk("next_digit_cnt", 32'(cnt0), 32'd1);
    pulse_reset();

    // Four-digit instance: correct code, then one wrong entry locks.
    digit(1, 4'd1); digit(1, 4'd2); digit(1, 4'd3); digit(1, 4'd4);
    chk("p4_open", 32'(flags(1)), 32'h4);
    wait_idle(1, n);
    chk("p4_open_len", 32'(n), 32'd3);
    digit(1, 4'd1); digit(1, 4'd2); digit(1, 4'd3); digit(1, 4'd5);
    chk("p4_lock", 32'(flags(1)), 32'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_dut1", 32'(dut_vec(1)), 32'h001);
    chk("async_reset_dut0", 32'(dut_vec(0)), 32'h001);
    @(negedge clk); rst_n = 1'b1;

    // Random stimulus, digits biased toward the password.
    repeat (3000) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        ins[k] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0)
          num[k] = 4'((p_pw[k] >> (4 * (p_n[k] - 1 - m_cnt[k]))) & 32'hF);
        else
          num[k] = 4'($urandom_range(0, 15));
      end
    end
    ins[0] = 1'b0; ins[1] = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
